// File: rtl/keymap_lookup_pkg.sv
// Shared constants, note codes and FSM encodings for the keymap lookup block.
// Optional feature macro used by the top: KEYMAP_HINT_BLINK_EN.
package keymap_lookup_pkg;

  localparam int         KEY_COUNT = 7;
  localparam logic [2:0] LAST_IDX  = 3'd6;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_MIN  = 4'd1;
  localparam logic [3:0] NOTE_MAX  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HIT  = 2'd2,
    ST_MISS = 2'd3
  } state_t;

  function automatic logic [6:0] key_onehot(input logic [2:0] idx);
    key_onehot = 7'b000_0001 << idx;
  endfunction

endpackage

// File: rtl/keymap_table.sv
// Seven-entry key-to-note register file: one write port and one combinational
// read port. Entries that were never written since reset read back invalid.
module keymap_table
  import keymap_lookup_pkg::*;
(
  input  logic       clk_div,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [2:0] i_wr_key,
  input  logic [3:0] i_wr_note,
  input  logic [2:0] i_rd_idx,
  output logic       o_rd_valid,
  output logic [3:0] o_rd_note
);

  logic [KEY_COUNT-1:0] r_valid;
  logic [3:0]           r_note [KEY_COUNT];

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < KEY_COUNT; i++) r_note[i] <= NOTE_REST;
    end else if (i_wr_en && (i_wr_key <= LAST_IDX)) begin
      r_valid[i_wr_key] <= 1'b1;
      r_note[i_wr_key]  <= i_wr_note;
    end
  end

  assign o_rd_valid = (i_rd_idx <= LAST_IDX) ? r_valid[i_rd_idx] : 1'b0;
  assign o_rd_note  = (i_rd_idx <= LAST_IDX) ? r_note[i_rd_idx]  : NOTE_REST;

endmodule

// File: rtl/keymap_lookup.sv
// Reverse lookup: finds the lowest key whose stored note equals the request.
// Define KEYMAP_HINT_BLINK_EN to blink the guide LED after a hit.
module keymap_lookup
  import keymap_lookup_pkg::*;
(
  input  logic       clk_div,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_key,
  input  logic [3:0] wr_note,
  input  logic       lock,
  input  logic       req,
  input  logic [3:0] note_in,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [2:0] key_idx,
  output logic [6:0] key_led
);

  state_t     r_state, w_next;
  logic [2:0] r_idx;
  logic [3:0] r_note_cap;
  logic       r_rest_wait;
  logic       r_done, r_found;
  logic [2:0] r_key_idx;
  logic [6:0] r_key_led;

  logic       w_rd_valid, w_match, w_accept, w_finish, w_wr;
  logic [3:0] w_rd_note;

  // Writes are blocked while scanning so a lock drop cannot alter the table.
  assign w_wr     = wr_en && !lock && (r_state != ST_SCAN);
  assign w_accept = (r_state == ST_IDLE) && req && lock;
  assign w_match  = w_rd_valid && (w_rd_note == r_note_cap);
  assign w_finish = (r_state == ST_HIT) || ((r_state == ST_MISS) && !r_rest_wait);

  keymap_table u_table (
    .clk_div    (clk_div),
    .rst        (rst),
    .i_wr_en    (w_wr),
    .i_wr_key   (wr_key),
    .i_wr_note  (wr_note),
    .i_rd_idx   (r_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_note  (w_rd_note)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (note_in == NOTE_REST) ? ST_MISS : ST_SCAN;
      ST_SCAN: begin
        if (w_match)                 w_next = ST_HIT;
        else if (r_idx == LAST_IDX)  w_next = ST_MISS;
      end
      ST_HIT:  w_next = ST_IDLE;
      ST_MISS: if (!r_rest_wait) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // A rest request idles one extra cycle in MISS to keep its two-cycle latency.
  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_note_cap  <= NOTE_REST;
      r_rest_wait <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_key_idx   <= '0;
      r_key_led   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish;
      if (w_accept) begin
        r_note_cap  <= note_in;
        r_idx       <= '0;
        r_found     <= 1'b0;
        r_key_idx   <= '0;
        r_key_led   <= '0;
        r_rest_wait <= (note_in == NOTE_REST);
      end else if (r_state == ST_SCAN) begin
        if (w_match)                 r_key_idx <= r_idx;
        else if (r_idx != LAST_IDX)  r_idx     <= r_idx + 3'd1;
      end else if (r_state == ST_HIT) begin
        r_found   <= 1'b1;
        r_key_led <= key_onehot(r_key_idx);
      end else if (r_state == ST_MISS) begin
        if (r_rest_wait) begin
          r_rest_wait <= 1'b0;
        end else begin
          r_found   <= 1'b0;
          r_key_idx <= '0;
          r_key_led <= '0;
        end
      end
    end
  end

`ifdef KEYMAP_HINT_BLINK_EN
  logic [2:0] r_blink_cnt;
  logic       r_blink_on;

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_accept) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_blink_cnt <= r_blink_cnt + 3'd1;
      if (r_found && (r_blink_cnt == 3'd7)) r_blink_on <= ~r_blink_on;
    end
  end

  assign key_led = r_key_led & {7{r_blink_on}};
`else
  assign key_led = r_key_led;
`endif

  assign busy    = (r_state == ST_SCAN);
  assign done    = r_done;
  assign found   = r_found;
  assign key_idx = r_key_idx;

endmodule

// File: tb/tb_keymap_lookup.sv
// Directed bench for keymap_lookup with a reference table model and a result
// scoreboard; also covers the KEYMAP_HINT_BLINK_EN build when that macro is set.
module tb_keymap_lookup;

  logic       clk_div, rst, wr_en, lock, req;
  logic [2:0] wr_key;
  logic [3:0] wr_note, note_in;
  logic       busy, done, found;
  logic [2:0] key_idx;
  logic [6:0] key_led;

  keymap_lookup dut (
    .clk_div (clk_div),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_key  (wr_key),
    .wr_note (wr_note),
    .lock    (lock),
    .req     (req),
    .note_in (note_in),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .key_idx (key_idx),
    .key_led (key_led)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  typedef struct {
    logic       found;
    logic [2:0] idx;
    logic [6:0] led;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic       m_valid [7];
  logic [3:0] m_note  [7];
  int         n_err = 0;
  int         n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] n);
    exp_t e;
    e.found = 1'b0; e.idx = 3'd0; e.led = 7'd0; e.lat = 8;
    if (n == 4'd0) begin
      e.lat = 2;
      return e;
    end
    for (int i = 0; i < 7; i++) begin
      if (m_valid[i] && m_note[i] == n) begin
        e.found = 1'b1; e.idx = 3'(i); e.led = 7'(1 << i); e.lat = i + 2;
        return e;
      end
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 7; i++) begin
      m_valid[i] = 1'b0;
      m_note[i]  = 4'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_div);
    rst = 1'b0;
    clear_model();
    @(negedge clk_div);
    rst = 1'b1;
  endtask

  task automatic write_key(input logic [2:0] k, input logic [3:0] n);
    @(negedge clk_div);
    wr_en = 1'b1; wr_key = k; wr_note = n;
    @(posedge clk_div); #1;
    wr_en = 1'b0;
    if (!lock && k <= 3'd6) begin
      m_valid[k] = 1'b1;
      m_note[k]  = n;
    end
  endtask

  task automatic lookup(input string tag, input logic [3:0] n, input bit disturb);
    exp_t e;
    int   cyc;
    bit   got;
    sb.push_back(model(n));
    @(negedge clk_div);
    req = 1'b1; note_in = n;
    @(posedge clk_div); #1;
    req = 1'b0;
    if (n != 4'd0) check({tag, "_busy"}, 32'(busy), 32'd1);
    got = 1'b0; cyc = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      if (disturb && c <= 3) begin
        lock = 1'b0; wr_en = 1'b1; wr_key = 3'd6; wr_note = 4'd3; req = 1'b1; note_in = 4'd5;
      end else if (disturb) begin
        lock = 1'b1; wr_en = 1'b0; req = 1'b0; note_in = n;
      end
      @(posedge clk_div); #1;
      if (done) begin got = 1'b1; cyc = c; end
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
      check({tag, "_found"},   32'(found), 32'(e.found));
      check({tag, "_key_idx"}, 32'(key_idx), 32'(e.idx));
      check({tag, "_key_led"}, 32'(key_led), 32'(e.led));
      @(posedge clk_div); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_found_hold"}, 32'(found), 32'(e.found));
      check({tag, "_idx_hold"},   32'(key_idx), 32'(e.idx));
    end
  endtask

  initial begin
    int ones, zeros;
    bit saw;
    rst = 1'b0; wr_en = 1'b0; wr_key = 3'd0; wr_note = 4'd0;
    lock = 1'b0; req = 1'b0; note_in = 4'd0;
    clear_model();
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_key_idx", 32'(key_idx), 32'd0);
    check("rst_key_led", 32'(key_led), 32'd0);
    @(negedge clk_div); rst = 1'b1;

    // reversed table: key k holds note 7-k
    for (int k = 0; k < 7; k++) write_key(3'(k), 4'(7 - k));
    lock = 1'b1;
    lookup("rev_n3", 4'd3, 1'b0);
    check("rev_n3_led_abs", 32'(key_led), 32'h10);
    lookup("rest", 4'd0, 1'b0);
    lookup("rev_n7", 4'd7, 1'b0);

    do_reset();
    lock = 1'b0;
    write_key(3'd2, 4'd5);
    write_key(3'd7, 4'd6);
    lock = 1'b1;
    lookup("single_miss", 4'd6, 1'b0);
    lookup("single_hit", 4'd5, 1'b0);

    do_reset();
    lock = 1'b0;
    write_key(3'd1, 4'd4);
    write_key(3'd5, 4'd4);
    lock = 1'b1;
    lookup("dup", 4'd4, 1'b0);

    write_key(3'd0, 4'd2);
    lookup("locked_wr", 4'd2, 1'b0);

    lock = 1'b0;
    @(negedge clk_div); req = 1'b1; note_in = 4'd4;
    @(posedge clk_div); #1; req = 1'b0;
    check("unlocked_req_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_div); #1;
      if (done || busy) saw = 1'b1;
    end
    check("unlocked_req_quiet", 32'(saw), 32'd0);

    do_reset();
    lock = 1'b0;
    for (int k = 0; k < 7; k++) write_key(3'(k), 4'(7 - k));
    lock = 1'b1;
    lookup("disturbed", 4'd1, 1'b1);

    @(negedge clk_div); req = 1'b1; note_in = 4'd1;
    @(posedge clk_div); #1; req = 1'b0;
    repeat (3) @(posedge clk_div);
    #1;
    check("midscan_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    clear_model();
    check("midscan_busy", 32'(busy), 32'd0);
    check("midscan_done", 32'(done), 32'd0);
    check("midscan_found", 32'(found), 32'd0);
    check("midscan_key_idx", 32'(key_idx), 32'd0);
    check("midscan_key_led", 32'(key_led), 32'd0);
    saw = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_div); #1;
      if (done) saw = 1'b1;
    end
    @(negedge clk_div); rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_div); #1;
      if (done) saw = 1'b1;
    end
    check("midscan_no_done", 32'(saw), 32'd0);
    lookup("cleared", 4'd1, 1'b0);

    lock = 1'b0;
    for (int k = 0; k < 7; k++) write_key(3'(k), 4'(7 - k));
    lock = 1'b1;
    lookup("key0", 4'd7, 1'b0);
    ones = 0; zeros = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk_div); #1;
      if (key_led == 7'b000_0001) ones++;
      else if (key_led == 7'd0) zeros++;
    end
`ifdef KEYMAP_HINT_BLINK_EN
    check("blink_toggles", 32'((ones >= 8) && (zeros >= 8) && (ones + zeros == 24)), 32'd1);
`else
    check("led_steady", 32'(ones), 32'd24);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
